// File: rtl/riscv_cpu.sv
// riscv_cpu: single-cycle RV32I core executing R-type, I-type ALU and branch instructions
module riscv_decoder (
  input  logic [31:0] inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        reg_we,
  output logic        is_branch
);
  logic is_r;
  logic is_i;
  // field extraction and immediate formation; inst[30] selects SUB only for R-type, SRA/SRAI for both
  always_comb begin
    is_r      = inst[6:0] == 7'b0110011;
    is_i      = inst[6:0] == 7'b0010011;
    is_branch = inst[6:0] == 7'b1100011;
    rs1       = inst[19:15];
    rs2       = inst[24:20];
    rd        = inst[11:7];
    funct3    = inst[14:12];
    use_imm   = is_i;
    reg_we    = is_r | is_i;
    alu_op    = {inst[30] & ((is_r & funct3 == 3'b000) | funct3 == 3'b101), funct3};
    imm       = is_branch ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
                          : {{20{inst[31]}}, inst[31:20]};
  end
endmodule

module riscv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] reg_mem [0:31];
  // x0 is never written, so it reads zero without a read-side mux
  always_comb begin
    rdata1 = reg_mem[raddr1];
    rdata2 = reg_mem[raddr2];
  end
  // single write port; reset clears every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 32; i++) reg_mem[i] <= '0;
    else if (we && waddr != 5'd0) reg_mem[waddr] <= wdata;
  end
endmodule

module riscv_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y
);
  // op[2:0] is funct3, op[3] picks SUB/SRA
  always_comb begin
    y = op[2:0] == 3'b000 ? (op[3] ? a - b : a + b) :
        op[2:0] == 3'b001 ? a << b[4:0] :
        op[2:0] == 3'b010 ? {31'd0, $signed(a) < $signed(b)} :
        op[2:0] == 3'b011 ? {31'd0, a < b} :
        op[2:0] == 3'b100 ? a ^ b :
        op[2:0] == 3'b101 ? (op[3] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0]) :
        op[2:0] == 3'b110 ? a | b : a & b;
  end
endmodule

module riscv_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        taken,
  input  logic [31:0] off,
  output logic [31:0] pc_counter
);
  logic [31:0] pc_d;
  // next pc: branch target when taken, otherwise sequential
  always_comb begin
    pc_d = taken ? pc_counter + off : pc_counter + 32'd4;
  end
  // pc only advances on valid cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_counter <= '0;
    else if (en) pc_counter <= pc_d;
  end
endmodule

module riscv_cpu (
  input logic        cpu_clk,
  input logic        cpu_rst,
  input logic [31:0] cpu_instruction,
  input logic        cpu_instruction_RDY_BSY
);
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic [31:0] imm, rd1, rd2, alu_y;
  logic        use_imm, reg_we, is_branch, taken;

  riscv_decoder d (
    .inst(cpu_instruction), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .alu_op(alu_op),
    .imm(imm), .use_imm(use_imm), .reg_we(reg_we), .is_branch(is_branch)
  );

  riscv_regfile r (
    .clk(cpu_clk), .rst(cpu_rst), .we(cpu_instruction_RDY_BSY & reg_we), .waddr(rd),
    .wdata(alu_y), .raddr1(rs1), .raddr2(rs2), .rdata1(rd1), .rdata2(rd2)
  );

  riscv_alu a (.a(rd1), .b(use_imm ? imm : rd2), .op(alu_op), .y(alu_y));

  // branch condition; funct3 010/011 are never taken
  always_comb begin
    taken = is_branch & (funct3 == 3'b000 ? rd1 == rd2 :
                         funct3 == 3'b001 ? rd1 != rd2 :
                         funct3 == 3'b100 ? $signed(rd1) < $signed(rd2) :
                         funct3 == 3'b101 ? $signed(rd1) >= $signed(rd2) :
                         funct3 == 3'b110 ? rd1 < rd2 :
                         funct3 == 3'b111 ? rd1 >= rd2 : 1'b0);
  end

  riscv_pc p (
    .clk(cpu_clk), .rst(cpu_rst), .en(cpu_instruction_RDY_BSY), .taken(taken), .off(imm),
    .pc_counter()
  );
endmodule

// File: tb/tb_riscv_cpu.sv
// tb_riscv_cpu: directed self-checking bench for riscv_cpu
module tb_riscv_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        rdy = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  riscv_cpu dut (.cpu_clk(clk), .cpu_rst(rst), .cpu_instruction(instr), .cpu_instruction_RDY_BSY(rdy));

  always #5 clk = ~clk;

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] it(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {im, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] bt(input logic [12:0] o, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3);
    return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic x(input int i, input logic [31:0] exp);
    chk($sformatf("x%0d", i), dut.r.reg_mem[i], exp);
  endtask

  task automatic pc(input logic [31:0] exp);
    chk("pc", dut.p.pc_counter, exp);
  endtask

  task automatic run(input logic [31:0] ins, input int n);
    instr = ins;
    rdy = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rdy = 1'b0;
  endtask

  initial begin
    logic [31:0] any_nz;
    #1 rst = 1'b1;
    #1;
    pc(32'd0); x(1, 0); x(31, 0);
    @(negedge clk) rst = 1'b0;
    run(it(12'd5, 5'd0, 3'b000, 5'd1), 1);             x(1, 5); pc(4);
    run(it(12'd5, 5'd1, 3'b000, 5'd2), 1);             x(2, 10); pc(8);
    run(rt(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 1);        x(3, 15); x(0, 0); pc(12);
    run(it(12'd5, 5'd0, 3'b000, 5'd1), 4);             x(1, 5); pc(28);
    run(rt(7'b0100000, 5'd3, 5'd2, 3'b111, 5'd4), 1);  x(4, 10); pc(32);
    run(rt(7'b0100000, 5'd1, 5'd3, 3'b000, 5'd5), 1);  x(5, 10); pc(36);
    run(bt(13'd2, 5'd4, 5'd2, 3'b000), 1);             pc(38);
    run(bt(13'd2, 5'd4, 5'd2, 3'b001), 1);             pc(42);
    run(it(12'd5, 5'd11, 3'b000, 5'd11), 3);           x(11, 15); pc(54);
    run(it(12'hFFF, 5'd0, 3'b000, 5'd6), 1);           x(6, 32'hFFFFFFFF); pc(58);
    run(bt(13'd8, 5'd1, 5'd6, 3'b100), 1);             pc(66);
    run(bt(13'd8, 5'd1, 5'd6, 3'b101), 1);             pc(70);
    run(bt(13'd8, 5'd1, 5'd6, 3'b110), 1);             pc(74);
    run(bt(13'd8, 5'd1, 5'd6, 3'b111), 1);             pc(82);
    run(bt(13'd8, 5'd1, 5'd1, 3'b010), 1);             pc(86);
    run(bt(13'h1FFC, 5'd0, 5'd0, 3'b000), 1);          pc(82);
    run(bt(13'd8, 5'd0, 5'd1, 3'b101), 2);             pc(98);
    run(it(12'h404, 5'd6, 3'b101, 5'd7), 1);           x(7, 32'hFFFFFFFF); pc(102);
    run(it(12'h01C, 5'd6, 3'b101, 5'd8), 1);           x(8, 32'hF); pc(106);
    run(rt(7'd0, 5'd1, 5'd6, 3'b010, 5'd9), 1);        x(9, 1);
    run(rt(7'd0, 5'd1, 5'd6, 3'b011, 5'd10), 1);       x(10, 0); pc(114);
    run(it(12'd7, 5'd0, 3'b000, 5'd0), 1);             x(0, 0); pc(118);
    run(rt(7'd0, 5'd6, 5'd1, 3'b001, 5'd12), 1);       x(12, 32'h80000000);
    run(rt(7'b0100000, 5'd1, 5'd6, 3'b101, 5'd13), 1); x(13, 32'hFFFFFFFF);
    run(rt(7'd0, 5'd1, 5'd6, 3'b101, 5'd14), 1);       x(14, 32'h07FFFFFF);
    run(rt(7'd0, 5'd1, 5'd6, 3'b100, 5'd15), 1);       x(15, 32'hFFFFFFFA); pc(134);
    run(it(12'hFFF, 5'd1, 3'b011, 5'd17), 1);          x(17, 1);
    run(it(12'd0, 5'd6, 3'b010, 5'd18), 1);            x(18, 1);
    run(it(12'h0F0, 5'd6, 3'b111, 5'd20), 1);          x(20, 32'hF0);
    run(it(12'd3, 5'd1, 3'b001, 5'd22), 1);            x(22, 32'd40);
    run(rt(7'b0100000, 5'd2, 5'd1, 3'b110, 5'd16), 1); x(16, 32'hF); pc(154);
    run(it(12'h400, 5'd1, 3'b000, 5'd25), 1);          x(25, 32'h405); pc(158);
    instr = it(12'd9, 5'd0, 3'b000, 5'd23);
    repeat (3) @(posedge clk);
    #1;
    x(23, 0); pc(158);
    run({12'd0, 5'd1, 3'b010, 5'd24, 7'b0000011}, 1); x(24, 0); pc(162);
    #2 rst = 1'b1;
    #1;
    pc(0); x(1, 0); x(6, 0);
    any_nz = '0;
    for (int i = 0; i < 32; i++) any_nz |= dut.r.reg_mem[i];
    chk("all_regs_zero", any_nz, 0);
    run(it(12'd5, 5'd0, 3'b000, 5'd1), 1);             x(1, 0); pc(0);
    @(negedge clk) rst = 1'b0;
    run(it(12'd5, 5'd0, 3'b000, 5'd1), 1);             x(1, 5); pc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
